// File: rtl/tb_irq_sched_pkg.sv
// Shared types and defaults for the e203 bench interrupt / bus-error scheduler.
//   irq_st_e   : per-IRQ-channel FSM states
//   berr_st_e  : ITCM bus-error window FSM states
//   CH_*       : channel index, also the arbiter priority (lower index wins)
//   DEF_*      : default committed-PC trigger points and LFSR seed
package tb_irq_sched_pkg;

   typedef enum logic [2:0] {
      IRQ_IDLE, IRQ_REQ, IRQ_WAIT, IRQ_ASSERT, IRQ_DONE
   } irq_st_e;

   typedef enum logic [2:0] {
      BE_IDLE, BE_REQ_LO, BE_WAIT_LO, BE_REQ_HI, BE_WAIT_HI, BE_DONE
   } berr_st_e;

   localparam int CH_EXT  = 0;
   localparam int CH_SFT  = 1;
   localparam int CH_TMR  = 2;
   localparam int CH_BERR = 3;
   localparam int NUM_IRQ = 3;
   localparam int NUM_CH  = 4;

   localparam logic [31:0] DEF_PC_ARM     = 32'h8000_015C;
   localparam logic [31:0] DEF_PC_TOHOST  = 32'h8000_0086;
   localparam logic [31:0] DEF_PC_EXT_ACK = 32'h8000_00A6;
   localparam logic [31:0] DEF_PC_SFT_ACK = 32'h8000_00BE;
   localparam logic [31:0] DEF_PC_TMR_ACK = 32'h8000_00D6;
   localparam logic [15:0] DEF_SEED       = 16'hACE1;

   // Fibonacci shift-left form, taps 16,14,13,11
   function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/tb_sched_lfsr16.sv
// 16-bit LFSR shared by all scheduler channels.
//   clk, rst_n : clock, async active-low reset (loads the seed)
//   en_i       : advance one step per cycle while high
//   lfsr_o     : current LFSR state
module tb_sched_lfsr16
   import tb_irq_sched_pkg::*;
#(
   parameter logic [15:0] SEED = DEF_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   output logic [15:0] lfsr_o
);

   // an all-zero state would lock up the register
   localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEF_SEED : SEED;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    lfsr_o <= INIT;
      else if (en_i) lfsr_o <= lfsr16_next(lfsr_o);
   end

endmodule

// File: rtl/tb_irq_sched.sv
// Cycle-exact interrupt / ITCM bus-error stimulus scheduler for the e203 bench.
// Committed PCs arm the scheduler, acknowledge each interrupt and count tohost
// writes; random delays come from one LFSR shared through a priority arbiter.
//   clk, rst_n          : clock, async active-low reset
//   en_i                : scheduler enable (low = clear arm, all FSMs idle)
//   cmt_valid_i/pc_i    : ALU commit strobe and PC
//   status_mie_i        : mstatus.MIE, gates bus-error injection
//   itcm_rsp_read_i     : ITCM response belongs to a read
//   ext/sft/tmr_irq_o   : registered interrupt drives
//   itcm_berr_o         : ITCM response-error drive
//   tohost_cnt_o        : saturating count of tohost commits
//   armed_o, done_o     : sticky arm flag, all channels finished
module tb_irq_sched
   import tb_irq_sched_pkg::*;
#(
   parameter int               PC_W       = 32,
   parameter logic [PC_W-1:0]  PC_ARM     = PC_W'(DEF_PC_ARM),
   parameter logic [PC_W-1:0]  PC_TOHOST  = PC_W'(DEF_PC_TOHOST),
   parameter logic [PC_W-1:0]  PC_EXT_ACK = PC_W'(DEF_PC_EXT_ACK),
   parameter logic [PC_W-1:0]  PC_SFT_ACK = PC_W'(DEF_PC_SFT_ACK),
   parameter logic [PC_W-1:0]  PC_TMR_ACK = PC_W'(DEF_PC_TMR_ACK),
   parameter int unsigned      STOP_CNT   = 32,
   parameter int               IRQ_DLY_W  = 10,
   parameter int               BERR_LO_W  = 4,
   parameter int               BERR_HI_W  = 8,
   parameter logic [15:0]      SEED       = DEF_SEED
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_i,
   input  logic            cmt_valid_i,
   input  logic [PC_W-1:0] cmt_pc_i,
   input  logic            status_mie_i,
   input  logic            itcm_rsp_read_i,
   output logic            ext_irq_o,
   output logic            sft_irq_o,
   output logic            tmr_irq_o,
   output logic            itcm_berr_o,
   output logic [31:0]     tohost_cnt_o,
   output logic            armed_o,
   output logic            done_o
);

   // counters hold d in 1..2^W, hence one extra bit
   localparam int ICW = IRQ_DLY_W + 1;
   localparam int BCW = BERR_HI_W + 1;

   logic [15:0]        lfsr;
   logic [31:0]        tohost_cnt_q;
   logic               armed_q;
   logic               stop;
   logic               hit_arm, hit_tohost;
   logic [NUM_CH-1:0]  req, gnt, ch_done;
   logic [NUM_IRQ-1:0] irq_q;

   assign hit_arm    = cmt_valid_i & (cmt_pc_i == PC_ARM);
   assign hit_tohost = cmt_valid_i & (cmt_pc_i == PC_TOHOST);
   // registered count only: a same-cycle tohost hit does not yet count
   assign stop       = tohost_cnt_q > 32'(STOP_CNT);

   tb_sched_lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en_i),
      .lfsr_o (lfsr)
   );

   // counts even while disabled so the bench can still track progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    tohost_cnt_q <= '0;
      else if (hit_tohost && (tohost_cnt_q != '1))   tohost_cnt_q <= tohost_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       armed_q <= 1'b0;
      else if (!en_i)   armed_q <= 1'b0;
      else if (hit_arm) armed_q <= 1'b1;
   end

   // fixed priority: isolate the lowest set request bit
   assign gnt = req & (~req + 4'd1);

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_irq
      localparam logic [PC_W-1:0] ACK_PC = (g == CH_EXT) ? PC_EXT_ACK :
                                           (g == CH_SFT) ? PC_SFT_ACK : PC_TMR_ACK;
      irq_st_e        st_q;
      logic [ICW-1:0] cnt_q;
      logic           irq_r;
      logic           ack;

      assign ack        = cmt_valid_i & (cmt_pc_i == ACK_PC);
      assign req[g]     = (st_q == IRQ_REQ);
      assign ch_done[g] = (st_q == IRQ_DONE);
      assign irq_q[g]   = irq_r;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q <= IRQ_IDLE; cnt_q <= '0; irq_r <= 1'b0;
         end else if (!en_i) begin
            st_q <= IRQ_IDLE; cnt_q <= '0; irq_r <= 1'b0;
         end else begin
            case (st_q)
               IRQ_IDLE: if (armed_q) st_q <= IRQ_REQ;
               IRQ_REQ: if (gnt[g]) begin
                  cnt_q <= ICW'(lfsr[IRQ_DLY_W-1:0]) + ICW'(1);
                  st_q  <= IRQ_WAIT;
               end
               // irq rises on the d-th edge after the grant edge
               IRQ_WAIT: if (cnt_q == ICW'(1)) begin
                  st_q  <= IRQ_ASSERT;
                  irq_r <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - ICW'(1);
               end
               IRQ_ASSERT: if (ack) begin
                  irq_r <= 1'b0;
                  st_q  <= stop ? IRQ_DONE : IRQ_REQ;
               end
               IRQ_DONE: ;
               default: st_q <= IRQ_IDLE;
            endcase
         end
      end
   end

   berr_st_e       be_st_q;
   logic [BCW-1:0] be_cnt_q;
   logic           win_q;

   assign req[CH_BERR]     = (be_st_q == BE_REQ_LO) || (be_st_q == BE_REQ_HI);
   assign ch_done[CH_BERR] = (be_st_q == BE_DONE);

   // windows start only after arm, so boot code never sees injected errors
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         be_st_q <= BE_IDLE; be_cnt_q <= '0; win_q <= 1'b0;
      end else if (!en_i) begin
         be_st_q <= BE_IDLE; be_cnt_q <= '0; win_q <= 1'b0;
      end else begin
         case (be_st_q)
            BE_IDLE: if (armed_q) be_st_q <= BE_REQ_LO;
            BE_REQ_LO: if (gnt[CH_BERR]) begin
               be_cnt_q <= BCW'(lfsr[BERR_LO_W-1:0]) + BCW'(1);
               be_st_q  <= BE_WAIT_LO;
            end
            BE_WAIT_LO: if (be_cnt_q == BCW'(1)) be_st_q  <= BE_REQ_HI;
                        else                      be_cnt_q <= be_cnt_q - BCW'(1);
            BE_REQ_HI: if (gnt[CH_BERR]) begin
               be_cnt_q <= BCW'(lfsr[BERR_HI_W-1:0]) + BCW'(1);
               win_q    <= 1'b1;
               be_st_q  <= BE_WAIT_HI;
            end
            BE_WAIT_HI: if (be_cnt_q == BCW'(1)) begin
               win_q   <= 1'b0;
               be_st_q <= stop ? BE_DONE : BE_REQ_LO;
            end else begin
               be_cnt_q <= be_cnt_q - BCW'(1);
            end
            BE_DONE: ;
            default: be_st_q <= BE_IDLE;
         endcase
      end
   end

   // only the low bits feed the delay counters
   logic unused_lfsr;
   assign unused_lfsr = ^lfsr;

   assign ext_irq_o    = irq_q[CH_EXT];
   assign sft_irq_o    = irq_q[CH_SFT];
   assign tmr_irq_o    = irq_q[CH_TMR];
   // MIE is low inside trap handlers, so errors only hit ordinary code reads
   assign itcm_berr_o  = win_q & status_mie_i & itcm_rsp_read_i;
   assign tohost_cnt_o = tohost_cnt_q;
   assign armed_o      = armed_q;
   assign done_o       = &ch_done;

endmodule
